// File: rtl/axis_consumer_pkg.sv
// Shared types and constants for the AXI-Stream row consumer: FSM states,
// AXI request field layout and the default request-beat magic value.
package axis_consumer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TRAILER,
        REQ_WAIT
    } row_state_t;

    localparam int REQ_WIDTH    = 72;
    localparam int REQ_ADDR_LSB = 0;
    localparam int REQ_DATA_LSB = 32;
    localparam int REQ_MODE_BIT = 64;

    localparam logic [63:0] REQ_MAGIC_DEFAULT = 64'hBEADCAFEFADEDBAD;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/axis_row_consumer_if.sv
// Generic valid/ready stream bundle used for both the row input and the AXI request output.
interface axis_row_consumer_if #(
    parameter int WIDTH = 512
) ();
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_throughput_meter.sv
// Sums accepted bytes over a window of CLK_HZ cycles and publishes the total in MiB (>> 20).
module axis_throughput_meter #(
    parameter int CLK_HZ  = 402832031,
    parameter int BYTES_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BYTES_W-1:0] byte_inc,
    output logic [31:0]        mb_per_sec
);
    localparam int                CNT_W    = $clog2(CLK_HZ + 1);
    localparam logic [CNT_W-1:0]  LAST_CYC = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cycle_cnt;
    logic [39:0]      acc;
    logic [39:0]      acc_sum;

    // The closing cycle's bytes still belong to the window being reported.
    assign acc_sum = acc + 40'(byte_inc);

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt  <= '0;
            acc        <= '0;
            mb_per_sec <= '0;
        end else if (cycle_cnt == LAST_CYC) begin
            mb_per_sec <= {12'd0, acc_sum[39:20]};
            acc        <= '0;
            cycle_cnt  <= '0;
        end else begin
            acc        <= acc_sum;
            cycle_cnt  <= cycle_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/axis_row_consumer.sv
// Row packet sink with in-band AXI request forwarding, idle watchdog and throughput meter.
// Define ROW_SEQ_CHECK_EN to build the header row-sequence checker.
module axis_row_consumer
    import axis_consumer_pkg::*;
#(
    parameter int          DATA_WIDTH   = 512,
    parameter int          ROW_BEATS    = 32,
    parameter int          CLK_HZ       = 402832031,
    parameter int          IDLE_TIMEOUT = 400000000,
    parameter logic [63:0] REQ_MAGIC    = REQ_MAGIC_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    axis_row_consumer_if.slave  axis_in,
    axis_row_consumer_if.master axi_req,
    output logic                lvds_data,
    output logic                row_complete,
    output logic [31:0]         rows_received,
    output logic [15:0]         timeout_count,
    output logic [15:0]         seq_error_count,
    output logic [31:0]         mb_per_sec
);
    localparam int              WD_W       = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_RELOAD  = WD_W'(IDLE_TIMEOUT);
    localparam logic [15:0]     BEAT_BYTES = 16'(DATA_WIDTH / 8);
    localparam logic [7:0]      LAST_BEAT  = 8'(ROW_BEATS);

    row_state_t           state, state_n;
    logic [7:0]           beat_cnt, beat_cnt_n;
    logic [WD_W-1:0]      wd, wd_n;
    logic                 in_ready, in_ready_n;
    logic                 req_valid, req_valid_n;
    logic [REQ_WIDTH-1:0] req_data, req_data_n;
    logic                 lvds_n, row_done_n;
    logic [31:0]          rows_n;
    logic [15:0]          tmo_n;
    logic [15:0]          data_bytes;
    logic                 beat;
    logic                 is_magic;

    assign beat     = axis_in.tvalid & in_ready;
    assign is_magic = (axis_in.tdata[DATA_WIDTH-1 -: 64] == REQ_MAGIC);

    assign axis_in.tready = in_ready;
    assign axi_req.tvalid = req_valid;
    assign axi_req.tdata  = req_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            wd            <= '0;
            in_ready      <= 1'b0;
            req_valid     <= 1'b0;
            req_data      <= '0;
            lvds_data     <= 1'b0;
            row_complete  <= 1'b0;
            rows_received <= '0;
            timeout_count <= '0;
        end else begin
            state         <= state_n;
            beat_cnt      <= beat_cnt_n;
            wd            <= wd_n;
            in_ready      <= in_ready_n;
            req_valid     <= req_valid_n;
            req_data      <= req_data_n;
            lvds_data     <= lvds_n;
            row_complete  <= row_done_n;
            rows_received <= rows_n;
            timeout_count <= tmo_n;
        end
    end

    always_comb begin
        state_n     = state;
        beat_cnt_n  = beat_cnt;
        wd_n        = wd;
        req_valid_n = req_valid;
        req_data_n  = req_data;
        lvds_n      = 1'b0;
        row_done_n  = 1'b0;
        rows_n      = rows_received;
        tmo_n       = timeout_count;
        data_bytes  = '0;

        unique case (state)
            IDLE: begin
                if (beat && is_magic) begin
                    req_data_n                        = '0;
                    req_data_n[REQ_ADDR_LSB +: 32]    = axis_in.tdata[31:0];
                    req_data_n[REQ_DATA_LSB +: 32]    = axis_in.tdata[63:32];
                    req_data_n[REQ_MODE_BIT]          = axis_in.tdata[64];
                    req_valid_n                       = 1'b1;
                    state_n                           = REQ_WAIT;
                end else if (beat) begin
                    lvds_n     = 1'b1;
                    beat_cnt_n = 8'd1;
                    wd_n       = WD_RELOAD;
                    state_n    = DATA;
                end
            end
            REQ_WAIT: begin
                if (axi_req.tready) begin
                    req_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            DATA: begin
                if (beat) begin
                    data_bytes = BEAT_BYTES;
                    wd_n       = WD_RELOAD;
                    beat_cnt_n = beat_cnt + 8'd1;
                    if (beat_cnt == LAST_BEAT) begin
                        state_n = TRAILER;
                    end
                end
            end
            TRAILER: begin
                if (beat) begin
                    row_done_n = 1'b1;
                    rows_n     = rows_received + 32'd1;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // A beat arriving on the expiry cycle suppresses the abort.
        if ((state == DATA || state == TRAILER) && !beat) begin
            if (wd == '0) begin
                state_n = IDLE;
                tmo_n   = sat_inc16(timeout_count);
            end else begin
                wd_n = wd - WD_W'(1);
            end
        end

        in_ready_n = (state_n != REQ_WAIT);
    end

    axis_throughput_meter #(
        .CLK_HZ (CLK_HZ),
        .BYTES_W(16)
    ) meter_u (
        .clk       (clk),
        .reset     (reset),
        .byte_inc  (data_bytes),
        .mb_per_sec(mb_per_sec)
    );

`ifdef ROW_SEQ_CHECK_EN
    logic        hdr_accept;
    logic        seq_seen;
    logic [31:0] seq_expected;
    logic [15:0] seq_err;

    assign hdr_accept      = beat && (state == IDLE) && !is_magic;
    assign seq_error_count = seq_err;

    // Expected value advances on every header, so aborted rows still count.
    always_ff @(posedge clk) begin
        if (reset) begin
            seq_seen     <= 1'b0;
            seq_expected <= '0;
            seq_err      <= '0;
        end else if (hdr_accept) begin
            if (seq_seen && (axis_in.tdata[31:0] != seq_expected)) begin
                seq_err <= sat_inc16(seq_err);
            end
            seq_expected <= axis_in.tdata[31:0] + 32'd1;
            seq_seen     <= 1'b1;
        end
    end
`else
    assign seq_error_count = '0;
`endif

endmodule

// File: tb/tb_axis_row_consumer.sv
// Directed and randomized checks of axis_row_consumer against a packet-level reference model.
module tb_axis_row_consumer;

    localparam int          DW   = 512;
    localparam int          RB   = 4;
    localparam int          HZ   = 1000;
    localparam int          TMO  = 20;
    localparam int          M_HZ = 17000;
    localparam logic [63:0] MAGIC = 64'hBEADCAFEFADEDBAD;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    axis_row_consumer_if #(.WIDTH(DW)) axis_in ();
    axis_row_consumer_if #(.WIDTH(72)) axi_req ();

    logic        lvds_data, row_complete;
    logic [31:0] rows_received, mb_per_sec;
    logic [15:0] timeout_count, seq_error_count;

    axis_row_consumer #(
        .DATA_WIDTH  (DW),
        .ROW_BEATS   (RB),
        .CLK_HZ      (HZ),
        .IDLE_TIMEOUT(TMO),
        .REQ_MAGIC   (MAGIC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .axis_in        (axis_in),
        .axi_req        (axi_req),
        .lvds_data      (lvds_data),
        .row_complete   (row_complete),
        .rows_received  (rows_received),
        .timeout_count  (timeout_count),
        .seq_error_count(seq_error_count),
        .mb_per_sec     (mb_per_sec)
    );

    // Second meter with a longer window so a whole MiB can be reached in a short run.
    logic        m_reset = 1'b1;
    logic [15:0] m_bytes = '0;
    logic [31:0] m_mb;

    axis_throughput_meter #(
        .CLK_HZ (M_HZ),
        .BYTES_W(16)
    ) meter_solo (
        .clk       (clk),
        .reset     (m_reset),
        .byte_inc  (m_bytes),
        .mb_per_sec(m_mb)
    );

    int          errors = 0;
    int          checks = 0;
    int unsigned exp_rows;
    int unsigned exp_tmo;
    int unsigned seq_err_model;
    bit          seq_have;
    logic [31:0] seq_next;
    logic [31:0] seq_cur;

    task automatic check_output(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        exp_rows      = 0;
        exp_tmo       = 0;
        seq_err_model = 0;
        seq_have      = 1'b0;
        seq_next      = '0;
    endfunction

    function automatic void model_header(input logic [31:0] seq);
        if (seq_have && seq != seq_next) seq_err_model++;
        seq_next = seq + 32'd1;
        seq_have = 1'b1;
    endfunction

    function automatic logic [15:0] exp_seq();
`ifdef ROW_SEQ_CHECK_EN
        return (seq_err_model > 65535) ? 16'hFFFF : 16'(seq_err_model);
`else
        return 16'h0;
`endif
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [DW-1:0] hdr_beat(input logic [31:0] seq);
        logic [DW-1:0] d;
        d = rand_beat();
        d[DW-1 -: 64] = 64'h0;
        d[31:0] = seq;
        return d;
    endfunction

    task automatic check_counters(input string tag);
        check_output({tag, "/rows"}, 72'(rows_received), 72'(exp_rows));
        check_output({tag, "/timeouts"}, 72'(timeout_count), 72'((exp_tmo > 65535) ? 65535 : exp_tmo));
        check_output({tag, "/seq_err"}, 72'(seq_error_count), 72'(exp_seq()));
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "/lvds"}, 72'(lvds_data), 72'(0));
        check_output({tag, "/rc"}, 72'(row_complete), 72'(0));
        check_output({tag, "/rows"}, 72'(rows_received), 72'(0));
        check_output({tag, "/tmo"}, 72'(timeout_count), 72'(0));
        check_output({tag, "/seq"}, 72'(seq_error_count), 72'(0));
        check_output({tag, "/mb"}, 72'(mb_per_sec), 72'(0));
        check_output({tag, "/in_tready"}, 72'(axis_in.tready), 72'(0));
        check_output({tag, "/req_tvalid"}, 72'(axi_req.tvalid), 72'(0));
        check_output({tag, "/req_tdata"}, axi_req.tdata, 72'(0));
    endtask

    task automatic idle(input int n);
        axis_in.tvalid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the beat is taken on the following posedge.
    task automatic send_beat(input logic [DW-1:0] data, input logic exp_lvds, input logic exp_rc);
        axis_in.tvalid = 1'b1;
        axis_in.tdata  = data;
        check_output("in_tready_row", 72'(axis_in.tready), 72'(1));
        @(negedge clk);
        axis_in.tvalid = 1'b0;
        check_output("lvds_data", 72'(lvds_data), 72'(exp_lvds));
        check_output("row_complete", 72'(row_complete), 72'(exp_rc));
    endtask

    task automatic send_row(input logic [31:0] seq, input int n_data, input bit trailer, input int max_gap);
        logic [DW-1:0] d;
        model_header(seq);
        send_beat(hdr_beat(seq), 1'b1, 1'b0);
        for (int i = 0; i < n_data; i++) begin
            idle($urandom_range(0, max_gap));
            d = rand_beat();
            if (i == 1) d[DW-1 -: 64] = MAGIC;
            send_beat(d, 1'b0, 1'b0);
        end
        if (trailer) begin
            idle($urandom_range(0, max_gap));
            send_beat(rand_beat(), 1'b0, 1'b1);
            exp_rows++;
        end
    endtask

    // A stalled row aborts on the (TMO+1)-th consecutive beatless cycle.
    task automatic wait_abort();
        idle(TMO);
        check_output("tmo_not_yet", 72'(timeout_count), 72'(exp_tmo));
        idle(1);
        exp_tmo++;
        check_output("tmo_fired", 72'(timeout_count), 72'(exp_tmo));
        check_output("rc_on_abort", 72'(row_complete), 72'(0));
    endtask

    task automatic send_req(input logic [31:0] addr, input logic [31:0] data, input logic mode,
                            input int latency, input bit hold, input logic [DW-1:0] hold_data);
        logic [DW-1:0] d;
        logic [71:0]   exp;
        d = rand_beat();
        d[DW-1 -: 64] = MAGIC;
        d[31:0]  = addr;
        d[63:32] = data;
        d[64]    = mode;
        exp = {7'd0, mode, data, addr};
        axis_in.tvalid = 1'b1;
        axis_in.tdata  = d;
        check_output("in_tready_req", 72'(axis_in.tready), 72'(1));
        @(negedge clk);
        axis_in.tvalid = hold;
        axis_in.tdata  = hold_data;
        check_output("req_lvds", 72'(lvds_data), 72'(0));
        check_output("req_tvalid", 72'(axi_req.tvalid), 72'(1));
        check_output("req_tdata", axi_req.tdata, exp);
        check_output("req_in_tready", 72'(axis_in.tready), 72'(0));
        for (int i = 0; i < latency; i++) begin
            @(negedge clk);
            check_output("req_hold_tvalid", 72'(axi_req.tvalid), 72'(1));
            check_output("req_hold_tdata", axi_req.tdata, exp);
            check_output("req_hold_in_tready", 72'(axis_in.tready), 72'(0));
            check_output("req_hold_lvds", 72'(lvds_data), 72'(0));
        end
        axi_req.tready = 1'b1;
        @(negedge clk);
        axi_req.tready = 1'b0;
        check_output("req_done_tvalid", 72'(axi_req.tvalid), 72'(0));
        check_output("req_done_in_tready", 72'(axis_in.tready), 72'(1));
        check_output("req_done_lvds", 72'(lvds_data), 72'(0));
    endtask

    initial begin
        logic [31:0]   seq;
        logic [39:0]   m_sum;
        logic [31:0]   m_prev;
        int            kind;

        axis_in.tvalid = 1'b0;
        axis_in.tdata  = '0;
        axi_req.tready = 1'b0;
        model_reset();
        seq_cur = 32'd0;

        $display("[TB] reset state");
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        check_output("tready_at_release", 72'(axis_in.tready), 72'(0));
        @(negedge clk);

        $display("[TB] back-to-back row");
        send_row(seq_cur, RB, 1'b1, 0);
        seq_cur++;
        check_counters("row1");

        $display("[TB] AXI request with back-pressure and a held header");
        send_req(32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 5, 1'b1, hdr_beat(seq_cur));
        send_row(seq_cur, RB, 1'b1, 0);
        seq_cur++;
        check_counters("req_row");

        $display("[TB] idle timeout");
        send_row(seq_cur, 2, 1'b0, 0);
        seq_cur++;
        wait_abort();
        check_counters("abort");
        send_row(seq_cur, 2, 1'b0, 0);
        seq_cur++;
        idle(TMO);
        send_beat(rand_beat(), 1'b0, 1'b0);
        check_output("beat_on_expiry_tmo", 72'(timeout_count), 72'(exp_tmo));
        send_beat(rand_beat(), 1'b0, 1'b0);
        send_beat(rand_beat(), 1'b0, 1'b1);
        exp_rows++;
        check_counters("expiry_beat");

        $display("[TB] randomized traffic");
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 9);
            seq  = ($urandom_range(0, 7) == 0) ? $urandom : seq_cur;
            if (kind <= 5) begin
                send_row(seq, RB, 1'b1, 3);
                seq_cur = seq + 32'd1;
            end else if (kind <= 7) begin
                send_row(seq, $urandom_range(0, RB), 1'b0, 3);
                seq_cur = seq + 32'd1;
                wait_abort();
            end else begin
                send_req($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 4), 1'b0, '0);
            end
            idle($urandom_range(0, 5));
            check_counters("random");
        end
        check_output("top_mb_per_sec", 72'(mb_per_sec), 72'(((HZ * DW / 8) >> 20)));

        $display("[TB] reset mid-row and mid-request");
        send_row(seq_cur, 2, 1'b0, 0);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("reset_mid_row");
        model_reset();
        reset = 1'b0;
        @(negedge clk);
        send_req(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 0, 1'b0, '0);
        axis_in.tvalid = 1'b1;
        axis_in.tdata  = rand_beat();
        axis_in.tdata[DW-1 -: 64] = MAGIC;
        @(negedge clk);
        axis_in.tvalid = 1'b0;
        check_output("second_req_tvalid", 72'(axi_req.tvalid), 72'(1));
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("reset_mid_req");
        model_reset();
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] row sequence 5,6,8,9 after reset");
        send_row(32'd5, RB, 1'b1, 1);
        send_row(32'd6, RB, 1'b1, 1);
        send_row(32'd8, RB, 1'b1, 1);
        send_row(32'd9, RB, 1'b1, 1);
        check_counters("seq");

        $display("[TB] throughput meter windows");
        m_reset = 1'b0;
        m_sum   = '0;
        for (int k = 0; k < M_HZ; k++) begin
            m_bytes = (k < 16383 || k == M_HZ - 1) ? 16'd64 : 16'd0;
            m_sum   = m_sum + 40'(m_bytes);
            @(negedge clk);
            if (k == M_HZ - 2) check_output("meter_before_close", 72'(m_mb), 72'(0));
        end
        check_output("meter_last_cycle_bytes", 72'(m_mb), 72'(m_sum >> 20));
        m_prev = 32'(m_sum >> 20);
        m_sum  = '0;
        for (int k = 0; k < M_HZ; k++) begin
            m_bytes = 16'($urandom_range(0, 127));
            m_sum   = m_sum + 40'(m_bytes);
            @(negedge clk);
            if (k == 100) check_output("meter_holds", 72'(m_mb), 72'(m_prev));
        end
        check_output("meter_random_window", 72'(m_mb), 72'(m_sum >> 20));
        m_bytes = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
